// File: rtl/edge_sched_pkg.sv
// Shared defaults and helpers for the edge event scheduler.
//   NCH_DEF  : default number of input channels
//   FILT_DEF : default number of identical samples that accept a level change
//   CW_DEF   : default per-channel pulse counter width
//   CHW_DEF  : channel index width for the default channel count
//   RUN_W    : width of the filter run counter (holds FILT-1 for FILT <= 15)
//   rr_index : cyclic channel index base+offs, wrapped into 0..n-1
package edge_sched_pkg;

  localparam int NCH_DEF  = 4;
  localparam int FILT_DEF = 3;
  localparam int CW_DEF   = 8;
  localparam int CHW_DEF  = $clog2(NCH_DEF);
  localparam int RUN_W    = 4;

  // Both inputs are already below n, so one conditional subtract wraps them.
  function automatic int rr_index(input int base, input int offs, input int n);
    int s;
    s = base + offs;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/edge_filter_ch.sv
// One input channel: glitch filter, qualified falling-edge strobe and the
// channel's pulse counter.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   i_en         : enable; qualifies falls (filter tracks regardless)
//   i_clr        : synchronous counter clear, wins over a simultaneous fall
//   i_d          : raw input sample
//   o_fall       : qualified falling edge this cycle (filtered 1->0 with i_en)
//   o_cnt_nxt    : counter value including this cycle's increment
module edge_filter_ch
  import edge_sched_pkg::*;
#(
  parameter int FILT = FILT_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic          i_d,
  output logic          o_fall,
  output logic [CW-1:0] o_cnt_nxt
);

  logic             r_lvl;
  logic [RUN_W-1:0] r_run;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_fall;
  logic [CW-1:0]    w_cnt_nxt;

  // The level flips on the FILT-th consecutive differing sample: FILT-1 of
  // them are already counted in r_run and the current one is the last.
  assign w_accept  = (i_d != r_lvl) && (r_run == RUN_W'(FILT - 1));
  assign w_fall    = w_accept && r_lvl && i_en;
  assign w_cnt_nxt = w_fall ? (r_cnt + CW'(1)) : r_cnt;

  assign o_fall    = w_fall;
  assign o_cnt_nxt = w_cnt_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lvl <= 1'b0;
      r_run <= '0;
      r_cnt <= '0;
    end else begin
      if (i_d == r_lvl) begin
        r_run <= '0;
      end else if (w_accept) begin
        r_lvl <= i_d;
        r_run <= '0;
      end else begin
        r_run <= r_run + RUN_W'(1);
      end
      r_cnt <= i_clr ? '0 : w_cnt_nxt;
    end
  end

endmodule

// File: rtl/edge_event_scheduler.sv
// Multi-channel filtered negative-edge event scheduler. Every channel has a
// glitch filter and pulse counter; qualified falls become pending events that
// a round-robin arbiter serializes onto one event port.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   en           : global enable for new events and count increments
//   clr          : synchronous clear of counters, pending, drop and pointer
//   d            : raw pulse inputs
//   evt_valid/evt_ready : event handshake
//   evt_chan     : channel index of presented event
//   evt_count    : channel count captured when the event was granted
//   drop         : sticky per-channel lost-event flags
//
// Handshake: an event transfers on a rising edge where evt_valid and
// evt_ready are both 1. While evt_valid=1 and evt_ready=0, evt_chan and
// evt_count hold. The output register may reload in the same cycle that the
// current event is accepted, giving one event per cycle.
module edge_event_scheduler
  import edge_sched_pkg::*;
#(
  parameter int NCH  = NCH_DEF,
  parameter int FILT = FILT_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic [NCH-1:0]          d,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [$clog2(NCH)-1:0]  evt_chan,
  output logic [CW-1:0]           evt_count,
  output logic [NCH-1:0]          drop
);

  localparam int CHW = $clog2(NCH);

  logic [NCH-1:0] w_fall;
  logic [CW-1:0]  w_cnt_nxt [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    edge_filter_ch #(
      .FILT (FILT),
      .CW   (CW)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_en      (en),
      .i_clr     (clr),
      .i_d       (d[g]),
      .o_fall    (w_fall[g]),
      .o_cnt_nxt (w_cnt_nxt[g])
    );
  end

  logic [NCH-1:0] r_pend;
  logic [NCH-1:0] r_drop;
  logic [CHW-1:0] r_ptr;
  logic           r_valid;
  logic [CHW-1:0] r_chan;
  logic [CW-1:0]  r_count;

  logic           w_free;
  logic           w_found;
  logic           w_fire;
  logic [CHW-1:0] w_idx;
  logic [NCH-1:0] w_gnt;

  assign w_free = ~r_valid | evt_ready;

  // First pending channel at or after r_ptr, searching cyclically.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!w_found && r_pend[rr_index(int'(r_ptr), k, NCH)]) begin
        w_found = 1'b1;
        w_idx   = CHW'(rr_index(int'(r_ptr), k, NCH));
      end
    end
  end

  // No new grant during clr: pending is being wiped that same edge.
  assign w_fire = w_free & w_found & ~clr;
  assign w_gnt  = w_fire ? (NCH'(1) << w_idx) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend  <= '0;
      r_drop  <= '0;
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_chan  <= '0;
      r_count <= '0;
    end else begin
      if (clr) begin
        r_pend <= '0;
        r_drop <= '0;
        r_ptr  <= '0;
      end else begin
        // A fall on the channel being granted re-arms pending without a drop.
        r_pend <= (r_pend & ~w_gnt) | w_fall;
        r_drop <= r_drop | (w_fall & r_pend & ~w_gnt);
        if (w_fire) begin
          r_ptr <= (w_idx == CHW'(NCH - 1)) ? '0 : w_idx + CHW'(1);
        end
      end

      // An already presented event survives clr until it is accepted.
      if (w_fire) begin
        r_valid <= 1'b1;
        r_chan  <= w_idx;
        r_count <= w_cnt_nxt[w_idx];
      end else if (w_free) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign evt_valid = r_valid;
  assign evt_chan  = r_chan;
  assign evt_count = r_count;
  assign drop      = r_drop;

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Self-checking bench for edge_event_scheduler (NCH=4, FILT=3, CW=8).
// The reference model treats the filter as "the last FILT samples all oppose
// the current level", keeps a count per channel and queues every qualified
// fall as an expected event; observed handshakes are matched per channel.
module tb_edge_event_scheduler;
  import edge_sched_pkg::*;

  localparam int NCH  = 4;
  localparam int FILT = 3;
  localparam int CW   = 8;
  localparam int CHW  = 2;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           reset_n;
  logic           en;
  logic           clr;
  logic           evt_ready;
  logic           evt_valid;
  logic [NCH-1:0] d;
  logic [NCH-1:0] drop;
  logic [CHW-1:0] evt_chan;
  logic [CW-1:0]  evt_count;

  edge_event_scheduler #(.NCH(NCH), .FILT(FILT), .CW(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .clr       (clr),
    .d         (d),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_chan  (evt_chan),
    .evt_count (evt_count),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  // ---------------- model / scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int             m_lvl  [NCH];
  int             m_seen [NCH];
  logic [FILT-1:0] m_hist [NCH];
  int             m_cnt  [NCH];
  logic [CHW+CW-1:0] exp_q[$];

  int got_cyc[$];
  int got_chan[$];
  int got_cnt[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_lvl[c]  = 0;
      m_seen[c] = 0;
      m_hist[c] = '0;
      m_cnt[c]  = 0;
    end
    exp_q.delete();
    got_cyc.delete();
    got_chan.delete();
    got_cnt.delete();
  endfunction

  function automatic void clear_got();
    got_cyc.delete();
    got_chan.delete();
    got_cnt.delete();
  endfunction

  // One clock: log a handshake seen before the edge, advance the model with
  // the inputs present at the edge, then settle #1 past the edge.
  task automatic tick();
    bit fell;
    if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
      got_cyc.push_back(cyc);
      got_chan.push_back(int'(evt_chan));
      got_cnt.push_back(int'(evt_count));
    end
    @(posedge clk);
    for (int c = 0; c < NCH; c++) begin
      fell = 1'b0;
      m_hist[c] = {m_hist[c][FILT-2:0], d[c]};
      if (m_seen[c] < FILT) m_seen[c]++;
      if (m_seen[c] == FILT) begin
        if (m_lvl[c] == 1 && m_hist[c] == '0) begin
          m_lvl[c] = 0;
          fell = 1'b1;
        end else if (m_lvl[c] == 0 && m_hist[c] == '1) begin
          m_lvl[c] = 1;
        end
      end
      if (clr) begin
        m_cnt[c] = 0;
      end else if (fell && en) begin
        m_cnt[c] = (m_cnt[c] + 1) % (1 << CW);
        exp_q.push_back({CHW'(c), CW'(m_cnt[c])});
      end
    end
    if (clr) exp_q.delete();
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic hold(input int ch, input logic val, input int n);
    d[ch] = val;
    run(n);
  endtask

  task automatic do_reset();
    d         = '0;
    en        = 1'b1;
    clr       = 1'b0;
    evt_ready = 1'b1;
    reset_n   = 1'b0;
    #2;
    model_reset();
    reset_n = 1'b1;
  endtask

  // Match every observed event to the oldest expected event of its channel.
  task automatic check_sb(input string tag);
    int hit;
    for (int i = 0; i < got_chan.size(); i++) begin
      hit = -1;
      for (int j = 0; j < exp_q.size(); j++) begin
        if (hit < 0 && int'(exp_q[j][CHW+CW-1:CW]) == got_chan[i]) hit = j;
      end
      check({tag, "_known"}, (hit >= 0) ? 32'd1 : 32'd0, 32'd1);
      if (hit >= 0) begin
        check({tag, "_count"}, got_cnt[i], int'(exp_q[hit][CW-1:0]));
        exp_q.delete(hit);
      end
    end
    check({tag, "_left"}, exp_q.size(), 0);
  endtask

  int t0;
  int rem [NCH];

  // ---------------- directed + random sequence ----------------
  initial begin
    d = '0; en = 1'b1; clr = 1'b0; evt_ready = 1'b1; reset_n = 1'b0;
    model_reset();
    #2;
    check("rst_valid", evt_valid, 0);
    check("rst_chan",  evt_chan,  0);
    check("rst_count", evt_count, 0);
    check("rst_drop",  drop,      0);
    reset_n = 1'b1;

    // Single fall on ch0: valid appears FILT edges after the edge that first
    // samples low, i.e. it is seen during cycle t0+FILT+1, for one cycle.
    hold(0, 1'b1, 20);
    clear_got();
    t0 = cyc;
    hold(0, 1'b0, 20);
    check("s1_n", got_chan.size(), 1);
    if (got_chan.size() == 1) begin
      check("s1_chan",  got_chan[0], 0);
      check("s1_count", got_cnt[0], 1);
      check("s1_time",  got_cyc[0], t0 + FILT + 1);
    end
    check_sb("s1_sb");

    // 2-cycle low glitch on ch1 is filtered out; the next real fall counts 1.
    hold(1, 1'b1, 20);
    clear_got();
    hold(1, 1'b0, 2);
    hold(1, 1'b1, 20);
    check("s2_none", got_chan.size(), 0);
    check("s2_drop", drop, 0);
    hold(1, 1'b0, 20);
    check("s2_n", got_chan.size(), 1);
    if (got_chan.size() == 1) check("s2_count", got_cnt[0], 1);
    check_sb("s2_sb");

    // Simultaneous falls on all channels, twice: round-robin 0..3 each time.
    do_reset();
    for (int b = 1; b <= 2; b++) begin
      d = '1;
      run(20);
      clear_got();
      d = '0;
      run(20);
      check("s3_n", got_chan.size(), NCH);
      if (got_chan.size() == NCH) begin
        for (int k = 0; k < NCH; k++) begin
          check("s3_chan",  got_chan[k], k);
          check("s3_count", got_cnt[k], b);
          check("s3_cyc",   got_cyc[k], got_cyc[0] + k);
        end
      end
      check_sb("s3_sb");
    end

    // Back-pressure on ch2: second fall pends, third sets drop and the
    // pending event then carries count 3.
    do_reset();
    hold(2, 1'b1, 20);
    evt_ready = 1'b0;
    hold(2, 1'b0, 10);
    check("s4_valid", evt_valid, 1);
    check("s4_chan",  evt_chan, 2);
    check("s4_count", evt_count, 1);
    hold(2, 1'b1, 6);
    hold(2, 1'b0, 6);
    check("s4_nodrop", drop, 0);
    hold(2, 1'b1, 6);
    hold(2, 1'b0, 6);
    check("s4_drop",  drop, 4'b0100);
    check("s4_hold_chan",  evt_chan, 2);
    check("s4_hold_count", evt_count, 1);
    clear_got();
    evt_ready = 1'b1;
    run(10);
    check("s4_n", got_chan.size(), 2);
    if (got_chan.size() == 2) begin
      check("s4_c0", got_cnt[0], 1);
      check("s4_c1", got_cnt[1], 3);
      check("s4_ch1", got_chan[1], 2);
      check("s4_cyc", got_cyc[1], got_cyc[0] + 1);
    end
    exp_q.delete();
    clr = 1'b1;
    run(1);
    clr = 1'b0;
    check("s4_clr_drop", drop, 0);
    clear_got();
    hold(2, 1'b1, 6);
    hold(2, 1'b0, 10);
    check("s4_after_clr_n", got_chan.size(), 1);
    if (got_chan.size() == 1) check("s4_after_clr_count", got_cnt[0], 1);

    // 256 falls on ch3: counts 1..255 then wrap to 0.
    do_reset();
    for (int k = 0; k < 256; k++) begin
      hold(3, 1'b1, 4);
      hold(3, 1'b0, 4);
    end
    run(10);
    check("s5_n", got_chan.size(), 256);
    if (got_chan.size() == 256) begin
      for (int k = 0; k < 256; k++) begin
        check("s5_count", got_cnt[k], (k + 1) % 256);
        check("s5_chan",  got_chan[k], 3);
      end
    end
    check("s5_drop", drop, 0);
    check_sb("s5_sb");

    // Asynchronous reset while an event is held by back-pressure.
    do_reset();
    hold(1, 1'b1, 10);
    evt_ready = 1'b0;
    hold(1, 1'b0, 10);
    check("s6_pre_valid", evt_valid, 1);
    check("s6_pre_chan",  evt_chan, 1);
    reset_n = 1'b0;
    #1;
    check("s6_valid", evt_valid, 0);
    check("s6_chan",  evt_chan, 0);
    check("s6_count", evt_count, 0);
    #2;
    model_reset();
    reset_n   = 1'b1;
    evt_ready = 1'b1;
    hold(1, 1'b1, 10);
    hold(1, 1'b0, 10);
    check("s6_n", got_chan.size(), 1);
    if (got_chan.size() == 1) check("s6_count", got_cnt[0], 1);

    // clr on the exact cycle of a fall suppresses it.
    do_reset();
    hold(0, 1'b1, 10);
    hold(0, 1'b0, 2);
    clr = 1'b1;
    run(1);
    clr = 1'b0;
    run(15);
    check("s7_none", got_chan.size(), 0);
    hold(0, 1'b1, 10);
    hold(0, 1'b0, 10);
    check("s7_n", got_chan.size(), 1);
    if (got_chan.size() == 1) check("s7_count", got_cnt[0], 1);
    check_sb("s7_sb");

    // en=0 blocks the fall and its count.
    clear_got();
    en = 1'b0;
    hold(1, 1'b1, 10);
    hold(1, 1'b0, 10);
    en = 1'b1;
    check("s8_none", got_chan.size(), 0);
    hold(1, 1'b1, 10);
    hold(1, 1'b0, 10);
    check("s8_n", got_chan.size(), 1);
    if (got_chan.size() == 1) check("s8_count", got_cnt[0], 1);
    check_sb("s8_sb");

    // Random pulse trains (including sub-FILT glitches) with random en.
    do_reset();
    for (int c = 0; c < NCH; c++) rem[c] = 0;
    repeat (1500) begin
      for (int c = 0; c < NCH; c++) begin
        if (rem[c] == 0) begin
          d[c]   = ~d[c];
          rem[c] = $urandom_range(1, 8);
        end
        rem[c]--;
      end
      en = ($urandom_range(0, 9) != 0);
      tick();
    end
    en = 1'b1;
    run(20);
    check("rnd_some", (got_chan.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    check_sb("rnd_sb");
    check("rnd_drop", drop, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_event_scheduler.md
# edge_event_scheduler

Multi-channel filter-protected negative-edge event scheduler. Each of NCH raw inputs gets its own glitch filter and per-channel pulse counter. Qualified falling edges become pending events. A round-robin arbiter serializes the events onto one valid/ready event port that carries the channel index and the channel's count. The block sits between the raw pulse inputs and a single downstream consumer (logger or CPU bridge) that cannot watch all channels at once.

## Interface
- NCH, 4: number of input channels (2..16)
- FILT, 3: consecutive identical samples required before a level change is accepted (1..15)
- CW, 8: per-channel pulse counter width
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  global enable; 0 suppresses new pending events and count increments
- clr  in  1  synchronous clear of counters, pending and drop flags
- d  in  NCH  raw pulse inputs, synchronous to clk
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts event
- evt_chan  out  $clog2(NCH)  channel index of presented event
- evt_count  out  CW  channel count value captured at grant
- drop  out  NCH  sticky per-channel flag: an event was lost

## Operation
- Filter, per channel: holds filtered level `lvl` and run counter `run`. If d equals lvl, run clears to 0. Otherwise run increments, and when it reaches FILT-1, lvl takes d and run clears. Pulses shorter than FILT cycles are ignored.
- Qualified fall: lvl goes 1->0 while en=1. This increments `cnt[i]`, which wraps modulo 2^CW. It sets pending[i]. If pending[i] is already set and not being granted this cycle, drop[i] is set instead; cnt still increments.
- Rising filtered edges only update lvl and are never events.
- Output register is free when evt_valid=0, or when evt_valid & evt_ready (the handshake is completing).
- Arbiter: when the output register is free and any pending bit is set, grant the first pending channel at or after `ptr`, searching cyclically. Load evt_chan=i and evt_count=cnt[i]. The count includes any increment made in the same cycle. Clear pending[i] and set ptr=i+1 mod NCH.
- Grant and a new fall on the same channel in the same cycle: pending[i] stays set for the new event. No drop.
- While evt_valid=1 and evt_ready=0, evt_chan and evt_count are held stable.
- en=0: filters keep tracking, no new pending or count updates. Already-pending events and an in-flight event still drain.
- clr=1: cnt, pending and drop clear, and ptr resets to 0. clr wins over a simultaneous fall. An already-presented event stays valid until accepted.

## Timing
- Reset values: evt_valid=0, evt_chan=0, evt_count=0, drop=0, every lvl=0, run=0, cnt=0, pending=0, ptr=0.
- The first low sample of d after lvl=1 is cycle 0. lvl falls and pending sets at the edge ending cycle FILT-1. evt_valid rises one edge later, FILT cycles after the first low sample, if the output is free.
- Throughput: one event per cycle while evt_ready=1 and events are pending.
- reset_n low clears all state immediately, including mid-handshake. Release is synchronous to clk.

## Structure
- Package edge_sched_pkg holds the default NCH, FILT and CW, and the localparam for the channel index width.
- One sub-module, edge_filter_ch, per channel. It contains the filter (lvl, run), the fall strobe and cnt. It is instantiated NCH times in a generate loop.
- The top level holds the pending/drop vectors, the round-robin pointer and the output register.

## Test plan
Parameters for all scenarios: NCH=4, FILT=3, CW=8, en=1, evt_ready=1 unless stated.
- Reset, then d[0]=1 for 20 cycles and 0 for 20 cycles -> exactly one event, chan 0 and count 1. evt_valid rises 3 cycles after the first low sample and lasts 1 cycle.
- d[1] high 20 cycles, low 2 cycles, high again -> no event, cnt[1] stays 0, drop=0.
- All four channels fall in the same cycle -> events chan 0,1,2,3 on four consecutive cycles, each with count 1. The next simultaneous batch starts at chan 0 (ptr wrapped).
- evt_ready=0 while the ch2 event (count 1) is presented, then two more falls on ch2 -> the first fall sets pending and the second sets drop[2]=1. After evt_ready=1: count 1 is accepted, then count 3. No further event.
- 256 qualified falls on ch3 -> event counts 1..255, then 0 (wrap). drop stays 0.
- reset_n pulsed low while evt_valid=1 and evt_ready=0 -> evt_valid=0 asynchronously, and all counts are 0 afterward. clr asserted on the cycle of a fall -> no event and cnt=0.
